// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and default constants for the FFT stage sequencer
//
// Contents:
//   fft_seq_state_t     sequencer state encoding {IDLE, RUN, DRAIN, DONE}
//   FFT_N_DEF           default log2 transform length
//   STAGE_COUNT_BW_DEF  default width of the stage counter
//   PIPE_LAT_DEF        default butterfly/write-back drain gap between stages
//   WD_MARGIN           extra RUN cycles tolerated beyond one stage's butterfly count
//   butterflies()       butterflies per stage for a given FFT_N
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_seq_state_t;

  localparam int FFT_N_DEF          = 10;
  localparam int STAGE_COUNT_BW_DEF = 4;
  localparam int PIPE_LAT_DEF       = 4;
  localparam int WD_MARGIN          = 4;

  // Each radix-2 stage processes 2^(fft_n-1) butterflies.
  function automatic int butterflies(input int fft_n);
    return 1 << (fft_n - 1);
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - sequencer <-> address generator handshake bundle
//
// Signals:
//   agen_run     run request to the address generator (sequencer drives)
//   agen_done    address generator finished the stage, level (agen drives)
//   stage_count  current FFT stage, 0..FFT_N-1 (sequencer drives)
//   bank_sel     ping-pong read bank; write bank is its inverse (sequencer drives)
// Modports:
//   master  the sequencer side
//   slave   the address generator side
interface fft_stage_sequencer_if #(
  parameter int STAGE_COUNT_BW = 4
);

  logic                      agen_run;
  logic                      agen_done;
  logic [STAGE_COUNT_BW-1:0] stage_count;
  logic                      bank_sel;

  modport master (
    output agen_run,
    output stage_count,
    output bank_sel,
    input  agen_done
  );

  modport slave (
    input  agen_run,
    input  stage_count,
    input  bank_sel,
    output agen_done
  );

endinterface

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - walks an in-place radix-2 FFT through its stages
//
// Purpose:
//   On an accepted start, runs the address generator once per stage, leaves a
//   PIPE_LAT-cycle drain gap between stages, flips the ping-pong bank each stage
//   and pulses fft_done after the last stage drains. A watchdog aborts a stage
//   whose agen_done never arrives and latches timeout_err.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high
//   start        single-cycle request, honoured only in IDLE
//   abort        synchronous return to IDLE from any state (highest priority)
//   busy         high from the cycle after an accepted start through DONE
//   fft_done     one-cycle pulse when the last stage has drained
//   timeout_err  sticky; cleared by reset or an accepted start
//   agen         master side of the address generator handshake
//
// All outputs are registered.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_N          = FFT_N_DEF,
  parameter int STAGE_COUNT_BW = STAGE_COUNT_BW_DEF,
  parameter int PIPE_LAT       = PIPE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  fft_done,
  output logic                  timeout_err,
  fft_stage_sequencer_if.master agen
);

  localparam int DRAIN_W  = $clog2(PIPE_LAT + 1);
  localparam int WD_W     = FFT_N + 1;
  localparam int WD_LIMIT = butterflies(FFT_N) + WD_MARGIN;

  localparam logic [STAGE_COUNT_BW-1:0] LAST_STAGE = STAGE_COUNT_BW'(FFT_N - 1);
  localparam logic [DRAIN_W-1:0]        DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);
  // The counter holds the number of RUN cycles already completed, so the stage
  // trips at the end of the cycle that brings it to WD_LIMIT.
  localparam logic [WD_W-1:0]           WD_TRIP    = WD_W'(WD_LIMIT - 1);

  fft_seq_state_t            state_q;
  logic                      busy_q;
  logic                      fft_done_q;
  logic                      timeout_err_q;
  logic                      agen_run_q;
  logic                      bank_sel_q;
  logic [STAGE_COUNT_BW-1:0] stage_q;
  logic [STAGE_COUNT_BW-1:0] stage_d;
  logic [DRAIN_W-1:0]        drain_q;
  logic [DRAIN_W-1:0]        drain_d;
  logic [WD_W-1:0]           wd_q;
  logic [WD_W-1:0]           wd_d;

  always_comb begin
    stage_d = stage_q + STAGE_COUNT_BW'(1);
    drain_d = drain_q - DRAIN_W'(1);
    // Saturate so a long stall can never wrap back below the trip point.
    wd_d    = (wd_q == {WD_W{1'b1}}) ? wd_q : wd_q + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      fft_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      agen_run_q    <= 1'b0;
      bank_sel_q    <= 1'b0;
      stage_q       <= '0;
      drain_q       <= '0;
      wd_q          <= '0;
    end else if (abort) begin
      // timeout_err is deliberately left alone: it only clears on a new start.
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      fft_done_q <= 1'b0;
      agen_run_q <= 1'b0;
      bank_sel_q <= 1'b0;
      stage_q    <= '0;
      drain_q    <= '0;
      wd_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fft_done_q <= 1'b0;
          if (start) begin
            state_q       <= RUN;
            busy_q        <= 1'b1;
            agen_run_q    <= 1'b1;
            timeout_err_q <= 1'b0;
            stage_q       <= '0;
            bank_sel_q    <= 1'b0;
            wd_q          <= '0;
          end
        end

        RUN: begin
          if (agen.agen_done) begin
            // Dropping run here makes it low from the first DRAIN cycle, which
            // also lets the address generator clear its counter for the next stage.
            state_q    <= DRAIN;
            agen_run_q <= 1'b0;
            drain_q    <= DRAIN_LOAD;
          end else if (wd_q == WD_TRIP) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            agen_run_q    <= 1'b0;
            timeout_err_q <= 1'b1;
            stage_q       <= '0;
            bank_sel_q    <= 1'b0;
            wd_q          <= '0;
          end else begin
            wd_q <= wd_d;
          end
        end

        DRAIN: begin
          if (drain_q == '0) begin
            if (stage_q == LAST_STAGE) begin
              state_q    <= DONE;
              fft_done_q <= 1'b1;
            end else begin
              state_q    <= RUN;
              agen_run_q <= 1'b1;
              stage_q    <= stage_d;
              bank_sel_q <= ~bank_sel_q;
              wd_q       <= '0;
            end
          end else begin
            drain_q <= drain_d;
          end
        end

        DONE: begin
          // start is not looked at here; a request in the DONE cycle is dropped.
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          fft_done_q <= 1'b0;
          stage_q    <= '0;
          bank_sel_q <= 1'b0;
        end

        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          fft_done_q <= 1'b0;
          agen_run_q <= 1'b0;
          stage_q    <= '0;
          bank_sel_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign fft_done         = fft_done_q;
  assign timeout_err      = timeout_err_q;
  assign agen.agen_run    = agen_run_q;
  assign agen.stage_count = stage_q;
  assign agen.bank_sel    = bank_sel_q;

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control stage directly upstream of the FFT address generator. Accepts a host start request, walks the in-place radix-2 FFT through its FFT_N stages by driving `stage_count` and the `agen_run`/`agen_done` handshake, and inserts a pipeline-drain gap between stages. It also toggles the ping-pong memory bank select and reports completion, busy and a sticky handshake-timeout error.

## Interface
- FFT_N, 10: log2 of transform length; stage count and butterflies per stage (2^(FFT_N-1)) derive from it.
- STAGE_COUNT_BW, 4: width of `stage_count`; must satisfy 2^STAGE_COUNT_BW >= FFT_N.
- PIPE_LAT, 4: butterfly/memory write-back drain cycles between stages; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request; honoured only in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- fft_done  out  1  one-cycle pulse when the last stage has drained.
- stage_count  out  STAGE_COUNT_BW  current stage, 0..FFT_N-1.
- agen_run  out  1  run request to the address generator.
- agen_done  in  1  address generator done (level, registered there).
- bank_sel  out  1  read bank for current stage; write bank is its inverse.
- timeout_err  out  1  sticky; cleared only by reset or an accepted start.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all outputs 0. `start`=1 -> RUN, with stage_count=0, bank_sel=0, timeout_err cleared.
- RUN: agen_run=1. On agen_done=1 -> DRAIN, and agen_run drops in the first DRAIN cycle.
- DRAIN: agen_run=0 for exactly PIPE_LAT cycles. This also guarantees the address generator sees run low and clears its counter. At the end of the count:
  - if stage_count==FFT_N-1 -> DONE;
  - otherwise stage_count+1, bank_sel toggles, -> RUN.
- DONE: one cycle, fft_done=1, busy=1. Then -> IDLE; stage_count and bank_sel return to 0.
- Watchdog:
  - A RUN-cycle counter clears on RUN entry.
  - If it reaches 2^(FFT_N-1)+4 without agen_done, timeout_err=1 and the state goes to IDLE.
  - No fft_done is issued in that case.
- Simultaneous events:
  - abort has priority over all transitions, including agen_done and a DONE exit.
  - Abort in DONE still ends that cycle's pulse; no extra pulse follows.
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
- Reset mid-operation: next cycle IDLE with all outputs 0; timeout_err cleared.
- Widths: drain counter $clog2(PIPE_LAT+1) bits; watchdog counter FFT_N+1 bits, saturating.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: RUN, agen_run=1, busy=1.
- With the matching address generator, agen_done arrives 2^(FFT_N-1) cycles after agen_run rises, so each RUN lasts 2^(FFT_N-1)+1 cycles.
- Per stage: 2^(FFT_N-1)+1+PIPE_LAT cycles.
- fft_done at cycle 1 + FFT_N·(2^(FFT_N-1)+1+PIPE_LAT).
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values of every output: 0.

## Structure
- Shared package `fft_pkg`:
  - state enum `fft_seq_state_t` {IDLE, RUN, DRAIN, DONE};
  - default FFT_N, STAGE_COUNT_BW, PIPE_LAT constants;
  - watchdog margin constant (4).
- No sub-module; the sequencer is one FSM plus drain and watchdog counters.
- The bench instantiates it together with the existing address generator.

## Test plan
- FFT_N=4, PIPE_LAT=4, real address generator, start at cycle 0: stage_count steps 0,1,2,3 at cycles 1,14,27,40. bank_sel toggles at each step. fft_done is a single pulse at cycle 53; busy is high on cycles 1..53.
- Same setup: agen_run is low for exactly 4 cycles between stages, and the address generator's MemAddr restarts at 0 each stage.
- agen_done forced 0: timeout_err=1 after 12 RUN cycles, state returns to IDLE, no fft_done. A following start clears timeout_err and the run completes normally.
- abort in stage 2 DRAIN: next cycle all outputs 0. start 5 cycles later gives a normal 52-cycle run.
- start pulsed at cycle 20 (busy) and in the DONE cycle: ignored, exactly one fft_done. Back-to-back start at cycle 54 is accepted.
- reset asserted mid-RUN of stage 1: next cycle all outputs 0, agen_run=0, and no fft_done is generated.
